alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
//
// PURPOSE
//   Execute-stage ALU with valid/ready handshakes. It consumes the 4-bit alu_ctrl
//   code driven by the ALU control decoder, plus two operands from the register-read/
//   immediate mux, and returns a registered result to writeback/branch logic.
//   Logic ops complete in one cycle. Shifts use an iterative 1-bit/cycle shifter,
//   unless the barrel option is compiled in.
//
// PARAMETERS
//   DATA_W   32   operand/result width; shift amount = op_b[$clog2(DATA_W)-1:0]
//
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       synchronous, active-high reset
//   in_valid   in   1       upstream presents alu_ctrl/op_a/op_b
//   in_ready   out  1       unit can accept an operation this cycle
//   alu_ctrl   in   4       alu_t {fun7_5,fun3}: ADD=0000 SUB=1000 SLL=0001 SLT=0010
//                           SLTU=0011 XOR=0100 SRL=0101 SRA=1101 OR=0110 AND=0111
//   op_a       in   DATA_W  operand A (rs1)
//   op_b       in   DATA_W  operand B (rs2 or immediate)
//   out_valid  out  1       result/zero are valid
//   out_ready  in   1       downstream accepts result
//   result     out  DATA_W  registered result
//   zero       out  1       registered (result == 0), used by BEQ/BNE
//
// BEHAVIOUR
//   - Reset: state=IDLE, out_valid=0, result=0, zero=0, shift count=0.
//     Reset mid-shift abandons the operation; no output is produced.
//   - FSM states: IDLE, SHIFT, DONE.
//   - in_ready = (state==IDLE) | (state==DONE & out_ready).
//     Transfer happens on in_valid & in_ready.
//   - Non-shift op accepted in cycle N:
//     result is computed combinationally, registered, state->DONE, out_valid=1 in N+1.
//   - Shift op (SLL/SRL/SRA) accepted:
//     - latch op_a and shamt; shamt==0 goes straight to DONE (same latency as non-shift).
//     - Otherwise enter SHIFT; shift 1 bit per cycle and decrement the count.
//     - At count==0, go to DONE; out_valid rises shamt+1 cycles after acceptance.
//     - SRA fills with the latched op_a MSB; SRL/SLL fill with 0.
//   - in_ready=0 throughout SHIFT.
//   - DONE: result/zero/out_valid stay stable until out_ready=1.
//     - out_ready=1 & in_valid=1: the new op is accepted in the same cycle (back-to-back, no bubble).
//     - out_ready=1 & in_valid=0: go to IDLE, out_valid=0.
//   - Arithmetic is modulo 2^DATA_W; ADD/SUB wrap with no overflow flag.
//     - SLT: signed compare, result is 1 or 0 zero-extended. SLTU: unsigned compare.
//   - Undefined alu_ctrl codes (1001,1010,1011,1100,1110,1111) complete in one cycle with result=0, zero=1.
//   - Inputs are sampled only on the transfer cycle; later changes are ignored.
//
// CONFIGURATION
//   ALU_BARREL_SHIFT_EN
//     defined: shifts use a combinational barrel shifter; every op has 1-cycle latency;
//              SHIFT state and counter are not instantiated.
//     undefined (default): iterative shifter as above; latency shamt+1 for shifts.
//
// TESTING
//   1. ADD 0x7FFFFFFF+0x1, out_ready=1 -> out_valid next cycle, result=0x80000000, zero=0.
//   2. SUB 5-5, then XOR/AND/OR back-to-back with in_valid held, out_ready=1
//      -> one result per cycle; first result=0, zero=1.
//   3. SRA op_a=0x80000000, op_b=31 -> in_ready=0 for 31 cycles, out_valid at cycle 32,
//      result=0xFFFFFFFF. With ALU_BARREL_SHIFT_EN: out_valid after 1 cycle.
//   4. SLT 0xFFFFFFFF<1 -> result=1; SLTU with the same operands -> result=0.
//   5. Backpressure: out_ready=0 for 5 cycles after a SLL 1<<4 -> result=0x10 held stable,
//      in_ready=0; drop on out_ready=1.
//   6. Assert reset at cycle 3 of an SRL by 20 -> next cycle out_valid=0, in_ready=1;
//      a fresh ADD 2+3 then returns 5.

Source files
------------

// File: rtl/alu_exec_if.sv
// ============================================================================
// Module   : alu_exec_if
// Brief    : Valid/ready request and response bundle for alu_exec_unit.
//            The master drives operations and accepts results. The slave
//            (the ALU) accepts operations and presents results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_exec_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execute-stage ALU with valid/ready handshakes and a registered
//            result/zero output. Logic and arithmetic ops take one cycle.
//            Shifts use an iterative 1-bit/cycle shifter unless the
//            ALU_BARREL_SHIFT_EN macro is defined. In that case a
//            combinational barrel shifter gives every op 1-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input wire logic  clk,
    input wire logic  reset,
    alu_exec_if.slave bus
);

    localparam int c_shamt_w = $clog2(DATA_W);

    // alu_ctrl encoding is {funct7[5], funct3}
    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b1000;
    localparam logic [3:0] c_op_sll  = 4'b0001;
    localparam logic [3:0] c_op_slt  = 4'b0010;
    localparam logic [3:0] c_op_sltu = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_srl  = 4'b0101;
    localparam logic [3:0] c_op_sra  = 4'b1101;
    localparam logic [3:0] c_op_or   = 4'b0110;
    localparam logic [3:0] c_op_and  = 4'b0111;

    localparam logic [1:0] c_st_idle  = 2'd0;
`ifndef ALU_BARREL_SHIFT_EN
    localparam logic [1:0] c_st_shift = 2'd1;
`endif
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]          r_state;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                w_in_ready;
    logic                w_accept;
    logic [c_shamt_w-1:0] w_shamt;
    logic [DATA_W-1:0]   w_alu_res;

`ifndef ALU_BARREL_SHIFT_EN
    logic                 w_is_shift;
    logic [c_shamt_w-1:0] r_cnt;
    logic [DATA_W-1:0]    r_shift_val;
    logic                 r_shift_left;
    logic                 r_shift_arith;
    logic [DATA_W-1:0]    w_shift_next;
`endif

    // A finished result can be retired and replaced in the same cycle
    assign w_in_ready = (r_state == c_st_idle) ||
                        ((r_state == c_st_done) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_shamt    = bus.op_b[c_shamt_w-1:0];

    // Single-cycle result. In iterative mode shifts yield op_a here, which
    // is the correct result only for the zero-amount case that bypasses SHIFT.
    always_comb begin
        w_alu_res  = '0;
`ifndef ALU_BARREL_SHIFT_EN
        w_is_shift = 1'b0;
`endif
        case (bus.alu_ctrl)
            c_op_add:  w_alu_res = bus.op_a + bus.op_b;
            c_op_sub:  w_alu_res = bus.op_a - bus.op_b;
            c_op_slt:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            c_op_sltu: w_alu_res = {{(DATA_W-1){1'b0}}, (bus.op_a < bus.op_b)};
            c_op_xor:  w_alu_res = bus.op_a ^ bus.op_b;
            c_op_or:   w_alu_res = bus.op_a | bus.op_b;
            c_op_and:  w_alu_res = bus.op_a & bus.op_b;
`ifdef ALU_BARREL_SHIFT_EN
            c_op_sll:  w_alu_res = bus.op_a << w_shamt;
            c_op_srl:  w_alu_res = bus.op_a >> w_shamt;
            c_op_sra:  w_alu_res = $unsigned($signed(bus.op_a) >>> w_shamt);
`else
            c_op_sll, c_op_srl, c_op_sra: begin
                w_is_shift = 1'b1;
                w_alu_res  = bus.op_a;
            end
`endif
            default:   w_alu_res = '0;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    // One-bit step of the iterative shifter; SRA replicates the latched MSB
    always_comb begin
        if (r_shift_left) begin
            w_shift_next = {r_shift_val[DATA_W-2:0], 1'b0};
        end else begin
            w_shift_next = {r_shift_arith & r_shift_val[DATA_W-1], r_shift_val[DATA_W-1:1]};
        end
    end
`endif

    // Control FSM, operand capture and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_result      <= '0;
            r_zero        <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            r_cnt         <= '0;
            r_shift_val   <= '0;
            r_shift_left  <= 1'b0;
            r_shift_arith <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_accept) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_shift_val   <= bus.op_a;
                            r_cnt         <= w_shamt;
                            r_shift_left  <= (bus.alu_ctrl == c_op_sll);
                            r_shift_arith <= (bus.alu_ctrl == c_op_sra);
                            r_state       <= c_st_shift;
                        end else
`endif
                        begin
                            r_result <= w_alu_res;
                            r_zero   <= (w_alu_res == '0);
                            r_state  <= c_st_done;
                        end
                    end else if ((r_state == c_st_done) && bus.out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                c_st_shift: begin
                    r_shift_val <= w_shift_next;
                    r_cnt       <= r_cnt - c_shamt_w'(1);
                    // Last step: publish the final shifted value
                    if (r_cnt == c_shamt_w'(1)) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                        r_state  <= c_st_done;
                    end
                end
`endif
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == c_st_done);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Self-checking scoreboard bench for alu_exec_unit. Honours
//            ALU_BARREL_SHIFT_EN when computing expected shift latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit c_barrel = 1'b1;
`else
    localparam bit c_barrel = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;
    logic [32:0] sb[$];   // {zero, result}

    alu_exec_if #(.DATA_W(32)) bus_if();

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int unsigned sh;
        sh = b % 32;
        case (c)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << sh;
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b1101: r = $unsigned($signed(a) >>> sh);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    function automatic int shift_lat(input int sh);
        return c_barrel ? 1 : sh + 1;
    endfunction

    // Present an op, wait for acceptance, record the expectation; in_valid stays high
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int waits);
        bus_if.in_valid = 1'b1;
        bus_if.alu_ctrl = c;
        bus_if.op_a     = a;
        bus_if.op_b     = b;
        waits = 0;
        @(negedge clk);
        while (!bus_if.in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!bus_if.in_ready) check_value("accept_timeout", 0, 1);
        else sb.push_back(model(c, a, b));
        @(posedge clk);
        #1;
    endtask

    // Drop in_valid (scrambling operands) and count cycles until out_valid
    task automatic wait_valid(output int n, output int ready_while_busy);
        bus_if.in_valid = 1'b0;
        bus_if.op_a     = 32'hDEAD_BEEF;
        bus_if.op_b     = 32'h0000_0013;
        bus_if.alu_ctrl = 4'b0000;
        n = 0;
        ready_while_busy = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus_if.out_valid && bus_if.in_ready) ready_while_busy++;
        end while (!bus_if.out_valid && n < 300);
    endtask

    // Scoreboard: compare every result as it is retired
    always @(negedge clk) begin
        if (!reset && bus_if.out_valid && bus_if.out_ready) begin
            if (sb.size() == 0) begin
                check_value("unexpected_output", 1, 0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check_value("result", bus_if.result, e[31:0]);
                check_value("zero", bus_if.zero, e[32]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, rb;
        logic [3:0] ops [10];
        ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
        n_compared   = 0;
        n_mismatched = 0;
        reset = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.alu_ctrl  = 4'b0000;
        bus_if.op_a      = '0;
        bus_if.op_b      = '0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_value("rst_out_valid", bus_if.out_valid, 0);
        check_value("rst_in_ready", bus_if.in_ready, 1);
        check_value("rst_result", bus_if.result, 0);
        check_value("rst_zero", bus_if.zero, 0);
        @(posedge clk); #1;

        // ADD wraps into the sign bit, one-cycle latency
        issue(4'b0000, 32'h7FFF_FFFF, 32'h1, w);
        wait_valid(n, rb);
        check_value("add_lat", n, 1);
        @(posedge clk); #1;

        // Back-to-back stream with in_valid held: no bubbles
        issue(4'b1000, 32'd5, 32'd5, w);
        issue(4'b0100, 32'hF0F0_1234, 32'h0FF0_1234, w);
        check_value("b2b_wait_xor", w, 0);
        issue(4'b0111, 32'hFFFF_0000, 32'h00FF_FF00, w);
        check_value("b2b_wait_and", w, 0);
        issue(4'b0110, 32'h1200_0000, 32'h0000_0034, w);
        check_value("b2b_wait_or", w, 0);
        wait_valid(n, rb);
        @(posedge clk); #1;

        // SRA by 31: sign fill, long latency, in_ready low while busy
        issue(4'b1101, 32'h8000_0000, 32'd31, w);
        wait_valid(n, rb);
        check_value("sra_lat", n, shift_lat(31));
        check_value("sra_busy_ready", rb, 0);
        @(posedge clk); #1;

        // Zero shift amount takes the single-cycle path
        issue(4'b0001, 32'hA5A5_0001, 32'h0000_0020, w);
        wait_valid(n, rb);
        check_value("sll0_lat", n, 1);
        @(posedge clk); #1;

        // Signed vs unsigned compare
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, w);
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1, w);
        wait_valid(n, rb);
        @(posedge clk); #1;

        // Undefined codes give result 0, zero 1
        foreach (ops[i]) begin end
        for (int c = 9; c < 16; c++) begin
            if (c != 13) issue(c[3:0], 32'h1234_5678, 32'h9ABC_DEF0, w);
        end
        wait_valid(n, rb);
        @(posedge clk); #1;

        // Backpressure: result held stable while out_ready is low
        bus_if.out_ready = 1'b0;
        issue(4'b0001, 32'd1, 32'd4, w);
        wait_valid(n, rb);
        check_value("sll_lat", n, shift_lat(4));
        repeat (5) begin
            @(negedge clk);
            check_value("bp_valid", bus_if.out_valid, 1);
            check_value("bp_result", bus_if.result, 32'h10);
            check_value("bp_in_ready", bus_if.in_ready, 0);
        end
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_value("bp_drop", bus_if.out_valid, 0);
        @(posedge clk); #1;

        // Reset in the middle of an SRL by 20 abandons it
        issue(4'b0101, 32'hF000_0000, 32'd20, w);
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_value("midrst_out_valid", bus_if.out_valid, 0);
        check_value("midrst_in_ready", bus_if.in_ready, 1);
        check_value("midrst_result", bus_if.result, 0);
        @(posedge clk); #1;
        issue(4'b0000, 32'd2, 32'd3, w);
        wait_valid(n, rb);
        check_value("post_rst_result", bus_if.result, 32'd5);
        @(posedge clk); #1;

        // Random mix of legal ops, streamed
        for (int i = 0; i < 24; i++) begin
            issue(ops[$urandom_range(9, 0)], $urandom, $urandom, w);
        end
        wait_valid(n, rb);
        repeat (3) @(negedge clk);
        check_value("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
